mem_stage_sram: RTL and testbench
=================================

# mem_stage_sram

Memory stage of the pipelined ARM core: consumes the execute stage's result bundle (ALU result as address, Rm value as store data, memory enables, write-back destination) and performs 32-bit loads/stores against an external 16-bit asynchronous SRAM. Each 32-bit access is split into two halfword phases. A `freeze` output stalls the upstream pipeline while the access is in flight. Non-memory instructions pass through with zero added latency.

## Interface
- `WAIT_CYCLES`, 1: extra cycles each halfword phase is held; legal range 1..7.
- `BASE_ADDR`, 32'd1024: data-memory base subtracted from the ALU result.
- `SRAM_AW`, 18: SRAM halfword address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in` in 1 each: control from the execute stage.
- `alu_res_in` in 32: byte address for loads/stores; write-back value otherwise.
- `val_rm_in` in 32: store data.
- `dest_in` in 4: write-back register.
- `wb_en_out`, `mem_r_en_out` out 1 each: combinational pass-through.
- `dest_out` out 4: combinational pass-through.
- `alu_res_out` out 32: combinational pass-through.
- `mem_result` out 32: registered load data.
- `freeze` out 1: pipeline stall request.
- `sram_addr` out SRAM_AW: halfword address.
- `sram_dq_out` out 16: write data.
- `sram_dq_oe` out 1: drive enable for `sram_dq_out`.
- `sram_dq_in` in 16: read data.
- `sram_we_n` out 1: active-low write strobe.
- `addr_err` out 1: present only with `MEM_STAGE_RANGE_CHECK_EN`.

## Operation
- Request: `req = mem_r_en_in | mem_w_en_in`.
  - If both enables are high, the access is a write and the read is suppressed.
- Address math:
  - `off = alu_res_in - BASE_ADDR` (32-bit, wraps).
  - Low halfword address: `{off[SRAM_AW:2], 1'b0}`.
  - High halfword address: `{off[SRAM_AW:2], 1'b1}`.
  - `off[1:0]` is ignored.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE → LO when `req`.
  - LO → HI after WAIT_CYCLES+1 cycles in LO.
  - HI → DONE after WAIT_CYCLES+1 cycles in HI.
  - DONE → IDLE unconditionally.
- Phase counter: 3-bit; cleared on every phase entry.
- Write phase:
  - `sram_dq_oe` = 1 for the whole phase.
  - `sram_dq_out` = `val_rm_in[15:0]` in LO, `[31:16]` in HI.
  - `sram_we_n` = 0 in every cycle of the phase except the last, where it is 1 (data held across the rising strobe edge).
- Read phase:
  - `sram_we_n` = 1, `sram_dq_oe` = 0.
  - `sram_dq_in` is captured on the last cycle of the phase: LO → `mem_result[15:0]`, HI → `mem_result[31:16]`.
  - `mem_result` is updated only by reads.
- `freeze = req & (state != DONE)`. It is combinational, so it is high in IDLE as soon as `req` arrives.
- Outside LO/HI:
  - `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0.
- Inputs must be held stable while `freeze` = 1; the upstream stall guarantees this.

## Timing
- Non-memory instruction: 0 cycles added, `freeze` = 0.
- Memory access: `freeze` is high for 2·(WAIT_CYCLES+1)+1 cycles, counting from the IDLE cycle.
  - The DONE cycle has `freeze` = 0; the pipeline advances on that edge.
  - `mem_result` is valid from DONE onward.
- Back-to-back memory instructions: the second one is seen in IDLE the cycle after DONE; no bubble beyond that IDLE cycle.
- Reset values: state IDLE, counter 0, `mem_result` 0, `sram_we_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `addr_err` 0.
- Reset asserted mid-access:
  - Immediate return to IDLE and the strobe is released.
  - A partial write of the low halfword may remain in SRAM; this is accepted.

## Configuration
- `MEM_STAGE_RANGE_CHECK_EN` defined:
  - An access with `off >= 2^(SRAM_AW+1)` is out of range. It still walks the FSM, but `sram_we_n` stays 1 and `sram_dq_oe` stays 0.
  - Loads return 0 in `mem_result`.
  - `addr_err` is registered: it is set in DONE of the faulting access and cleared in DONE of the next in-range access.
- Not defined: no check, no `addr_err` port; the address is truncated to SRAM_AW bits.

## Structure
- Package `mem_stage_pkg`:
  - state enum (IDLE, LO, HI, DONE);
  - default `BASE_ADDR`, `SRAM_AW`;
  - `WAIT_CYCLES` upper bound.
- Sub-module `sram_ctrl`: FSM, counter, SRAM pins and `mem_result`.
- The top level holds the pass-throughs, address math and `freeze`.

## Test plan
- ADD instruction, `wb_en_in` = 1, `alu_res_in` = 32'h5 → pass-throughs equal the inputs, `freeze` = 0, SRAM idle (`sram_we_n` = 1).
- STR with `alu_res_in` = 1028, `val_rm_in` = 32'hDEADBEEF, WAIT_CYCLES = 1:
  - `sram_addr` = 2 with 16'hBEEF, then 3 with 16'hDEAD;
  - `sram_we_n` low 1 cycle per phase;
  - `freeze` high 5 cycles.
- LDR from 1028 after that store, SRAM model → `mem_result` = 32'hDEADBEEF in DONE; `freeze` high 5 cycles.
- Both `mem_r_en_in` and `mem_w_en_in` high → write is performed, `mem_result` unchanged.
- Reset driven low during HI of a store → next cycle state IDLE, `sram_we_n` = 1, `freeze` follows the combinational rule; a subsequent LDR completes normally.
- With `MEM_STAGE_RANGE_CHECK_EN`: LDR at `BASE_ADDR` + 2^19 → no strobe, `mem_result` = 0, `addr_err` = 1; an in-range LDR next clears it.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM state type and default parameters for the SRAM memory stage
package mem_stage_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int DEF_SRAM_AW = 18;
    localparam int MAX_WAIT_CYCLES = 7;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: two-phase halfword sequencer for a 16-bit async SRAM, owns the pins and load data
// Optional MEM_STAGE_RANGE_CHECK_EN: adds an in-range qualifier and the registered addr_err flag
module sram_ctrl import mem_stage_pkg::*; #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW = DEF_SRAM_AW
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic wr,
`ifdef MEM_STAGE_RANGE_CHECK_EN
    input  logic ok,
    output logic addr_err,
`endif
    input  logic [SRAM_AW-2:0] word,
    input  logic [31:0] wdata,
    output logic done,
    output logic [31:0] mem_result,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic sram_we_n
);
    state_t state, state_nx;
    logic [2:0] cnt;
    logic in_ph, hi, last;
`ifndef MEM_STAGE_RANGE_CHECK_EN
    logic ok;
    assign ok = 1'b1;
`endif
    assign in_ph = state == LO || state == HI;
    assign hi = state == HI;
    assign last = cnt == 3'(WAIT_CYCLES);
    assign done = state == DONE;
    assign sram_addr = in_ph ? {word, hi} : '0;
    assign sram_dq_out = hi ? wdata[31:16] : wdata[15:0];
    assign sram_dq_oe = in_ph & wr & ok;
    assign sram_we_n = ~(sram_dq_oe & ~last);
    // next state: each phase lasts WAIT_CYCLES+1 cycles, DONE always falls back to IDLE
    always_comb begin
        state_nx = state == IDLE ? (req ? LO : IDLE) :
                   state == DONE ? IDLE :
                   last ? (hi ? DONE : HI) : state;
    end
    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    // phase counter, zero on entry to every phase
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= (in_ph && !last) ? cnt + 3'd1 : 3'd0;
    // load data captured on the last cycle of each read phase
    always_ff @(posedge clk or negedge rst)
        if (!rst) mem_result <= '0;
        else if (in_ph && last && !wr) begin
            if (hi) mem_result[31:16] <= ok ? sram_dq_in : 16'd0;
            else mem_result[15:0] <= ok ? sram_dq_in : 16'd0;
        end
`ifdef MEM_STAGE_RANGE_CHECK_EN
    // error flag takes effect in DONE of each access
    always_ff @(posedge clk or negedge rst)
        if (!rst) addr_err <= 1'b0;
        else if (hi && last) addr_err <= ~ok;
`endif
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: pipeline memory stage, 32-bit loads/stores over a 16-bit async SRAM with freeze
// Optional MEM_STAGE_RANGE_CHECK_EN: flags (addr_err) and suppresses accesses outside the SRAM window
module mem_stage_sram import mem_stage_pkg::*; #(
    parameter int WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int SRAM_AW = DEF_SRAM_AW
) (
    input  logic clk,
    input  logic rst,
    input  logic wb_en_in,
    input  logic mem_r_en_in,
    input  logic mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0] dest_in,
    output logic wb_en_out,
    output logic mem_r_en_out,
    output logic [3:0] dest_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_result,
    output logic freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic sram_dq_oe,
    input  logic [15:0] sram_dq_in,
`ifdef MEM_STAGE_RANGE_CHECK_EN
    output logic addr_err,
`endif
    output logic sram_we_n
);
    logic [31:0] off;
    logic req, done, unused_bits;
    assign wb_en_out = wb_en_in;
    assign mem_r_en_out = mem_r_en_in;
    assign dest_out = dest_in;
    assign alu_res_out = alu_res_in;
    assign off = alu_res_in - BASE_ADDR;
    assign req = mem_r_en_in | mem_w_en_in;
    assign freeze = req & ~done;
`ifdef MEM_STAGE_RANGE_CHECK_EN
    logic ok;
    assign ok = off[31:SRAM_AW+1] == '0;
    assign unused_bits = ^off[1:0];
`else
    assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0]};
`endif
    sram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .req(req),
        .wr(mem_w_en_in),
`ifdef MEM_STAGE_RANGE_CHECK_EN
        .ok(ok),
        .addr_err(addr_err),
`endif
        .word(off[SRAM_AW:2]),
        .wdata(val_rm_in),
        .done(done),
        .mem_result(mem_result),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n)
    );
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: table-driven cycle checks of the SRAM memory stage against a behavioural SRAM
module tb_mem_stage_sram;
    logic clk = 1'b0;
    logic rst, wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_rm_in;
    logic [3:0] dest_in;
    logic wb_en_out, mem_r_en_out, freeze, sram_dq_oe, sram_we_n;
    logic [3:0] dest_out;
    logic [31:0] alu_res_out, mem_result;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
`ifdef MEM_STAGE_RANGE_CHECK_EN
    logic addr_err;
`endif
    logic [15:0] sram [0:(1<<18)-1];
    int tests = 0;
    int fails = 0;

    mem_stage_sram dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .dest_out(dest_out),
        .alu_res_out(alu_res_out), .mem_result(mem_result), .freeze(freeze),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
`ifdef MEM_STAGE_RANGE_CHECK_EN
        .addr_err(addr_err),
`endif
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // behavioural SRAM: write while strobe is low, asynchronous read
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    assign sram_dq_in = sram[sram_addr];

    typedef struct {
        logic wb, rd, wr;
        logic [31:0] alu, rm;
        logic [3:0] dest;
        logic f, we_n, oe;
        logic [17:0] addr;
        logic [15:0] dq;
        logic [31:0] res;
    } vec_t;
    vec_t vecs [26];

    function automatic vec_t mk(input logic wb, rd, wr, input logic [31:0] alu, rm, input logic [3:0] dest,
                                input logic f, we_n, oe, input logic [17:0] addr, input logic [15:0] dq,
                                input logic [31:0] res);
        vec_t v;
        v.wb = wb; v.rd = rd; v.wr = wr; v.alu = alu; v.rm = rm; v.dest = dest;
        v.f = f; v.we_n = we_n; v.oe = oe; v.addr = addr; v.dq = dq; v.res = res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wb, rd, wr, input logic [31:0] alu, rm, input logic [3:0] dest);
        wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
        alu_res_in = alu; val_rm_in = rm; dest_in = dest;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen, strobe;
        // ADD, STR 1028, LDR 1028 back-to-back, STR+LDR both high, LDR 1032, ADD
        vecs[0]  = mk(1,0,0,32'd5,0,3,          0,1,0,0,0,0);
        vecs[1]  = mk(0,0,1,32'd1028,32'hDEADBEEF,0, 1,1,0,0,0,0);
        vecs[2]  = mk(0,0,1,32'd1028,32'hDEADBEEF,0, 1,0,1,2,16'hBEEF,0);
        vecs[3]  = mk(0,0,1,32'd1028,32'hDEADBEEF,0, 1,1,1,2,16'hBEEF,0);
        vecs[4]  = mk(0,0,1,32'd1028,32'hDEADBEEF,0, 1,0,1,3,16'hDEAD,0);
        vecs[5]  = mk(0,0,1,32'd1028,32'hDEADBEEF,0, 1,1,1,3,16'hDEAD,0);
        vecs[6]  = mk(0,0,1,32'd1028,32'hDEADBEEF,0, 0,1,0,0,0,0);
        vecs[7]  = mk(1,1,0,32'd1028,0,4, 1,1,0,0,0,0);
        vecs[8]  = mk(1,1,0,32'd1028,0,4, 1,1,0,2,0,0);
        vecs[9]  = mk(1,1,0,32'd1028,0,4, 1,1,0,2,0,0);
        vecs[10] = mk(1,1,0,32'd1028,0,4, 1,1,0,3,0,32'h0000BEEF);
        vecs[11] = mk(1,1,0,32'd1028,0,4, 1,1,0,3,0,32'h0000BEEF);
        vecs[12] = mk(1,1,0,32'd1028,0,4, 0,1,0,0,0,32'hDEADBEEF);
        vecs[13] = mk(0,1,1,32'd1032,32'h12345678,0, 1,1,0,0,0,32'hDEADBEEF);
        vecs[14] = mk(0,1,1,32'd1032,32'h12345678,0, 1,0,1,4,16'h5678,32'hDEADBEEF);
        vecs[15] = mk(0,1,1,32'd1032,32'h12345678,0, 1,1,1,4,16'h5678,32'hDEADBEEF);
        vecs[16] = mk(0,1,1,32'd1032,32'h12345678,0, 1,0,1,5,16'h1234,32'hDEADBEEF);
        vecs[17] = mk(0,1,1,32'd1032,32'h12345678,0, 1,1,1,5,16'h1234,32'hDEADBEEF);
        vecs[18] = mk(0,1,1,32'd1032,32'h12345678,0, 0,1,0,0,0,32'hDEADBEEF);
        vecs[19] = mk(1,1,0,32'd1032,0,5, 1,1,0,0,0,32'hDEADBEEF);
        vecs[20] = mk(1,1,0,32'd1032,0,5, 1,1,0,4,0,32'hDEADBEEF);
        vecs[21] = mk(1,1,0,32'd1032,0,5, 1,1,0,4,0,32'hDEADBEEF);
        vecs[22] = mk(1,1,0,32'd1032,0,5, 1,1,0,5,0,32'hDEAD5678);
        vecs[23] = mk(1,1,0,32'd1032,0,5, 1,1,0,5,0,32'hDEAD5678);
        vecs[24] = mk(1,1,0,32'd1032,0,5, 0,1,0,0,0,32'h12345678);
        vecs[25] = mk(1,0,0,32'hABCD,0,7, 0,1,0,0,0,32'h12345678);

        rst = 1'b0;
        drive(0,0,0,0,0,0);
        sram[0] = 16'hFFFF;
        sram[1] = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_we_n", sram_we_n, 1);
        chk("reset_oe", sram_dq_oe, 0);
        chk("reset_addr", sram_addr, 0);
        chk("reset_result", mem_result, 0);
        chk("reset_freeze", freeze, 0);
`ifdef MEM_STAGE_RANGE_CHECK_EN
        chk("reset_addr_err", addr_err, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vecs[i].wb, vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].rm, vecs[i].dest);
            #1;
            chk($sformatf("v%0d_freeze", i), freeze, vecs[i].f);
            chk($sformatf("v%0d_we_n", i), sram_we_n, vecs[i].we_n);
            chk($sformatf("v%0d_oe", i), sram_dq_oe, vecs[i].oe);
            chk($sformatf("v%0d_addr", i), sram_addr, vecs[i].addr);
            chk($sformatf("v%0d_result", i), mem_result, vecs[i].res);
            chk($sformatf("v%0d_pass", i), {wb_en_out, mem_r_en_out, dest_out, alu_res_out},
                {vecs[i].wb, vecs[i].rd, vecs[i].dest, vecs[i].alu});
            if (vecs[i].oe) chk($sformatf("v%0d_dq", i), sram_dq_out, vecs[i].dq);
        end

        // reset during the high phase of a store, then a normal load
        @(negedge clk);
        drive(0,0,1,32'd1036,32'hAAAA5555,0);
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_hi_strobe", sram_we_n, 0);
        chk("midrst_hi_addr", sram_addr, 7);
        rst = 1'b0;
        #1;
        chk("midrst_we_n", sram_we_n, 1);
        chk("midrst_oe", sram_dq_oe, 0);
        chk("midrst_addr", sram_addr, 0);
        chk("midrst_freeze", freeze, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(1,1,0,32'd1028,0,2);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!freeze) begin
                seen = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        chk("postrst_done_seen", seen, 1);
        chk("postrst_freeze_len", n, 5);
        chk("postrst_result", mem_result, 32'hDEADBEEF);

`ifdef MEM_STAGE_RANGE_CHECK_EN
        // out-of-range load: no strobe, zero data, error flag; next in-range load clears it
        @(negedge clk);
        drive(1,1,0,32'd1024 + 32'h80000,0,2);
        n = 0;
        seen = 1'b0;
        strobe = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            strobe = strobe | ~sram_we_n | sram_dq_oe;
            if (!freeze) begin
                seen = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        chk("oor_done_seen", seen, 1);
        chk("oor_freeze_len", n, 5);
        chk("oor_no_strobe", strobe, 0);
        chk("oor_result", mem_result, 0);
        chk("oor_addr_err", addr_err, 1);
        @(negedge clk);
        drive(1,1,0,32'd1028,0,2);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!freeze) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("inr_done_seen", seen, 1);
        chk("inr_addr_err", addr_err, 0);
        chk("inr_result", mem_result, 32'hDEADBEEF);
`endif

        @(negedge clk);
        drive(0,0,0,0,0,0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
